// File: rtl/cook_timer_pkg.sv
// rtl/cook_timer_pkg.sv - shared types and constants for the multi-channel cook timer
// Purpose: channel state enum, seconds-per-minute constant and selector width helper.
// Ports: none (package).
package cook_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SET   = 2'd1,
        ST_RUN   = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    localparam int SEC_PER_MIN = 60;

    // Selector width: max(1, clog2(channels)).
    function automatic int cw_of(input int channels);
        return (channels <= 2) ? 1 : $clog2(channels);
    endfunction

endpackage

// File: rtl/multi_cook_timer_if.sv
// rtl/multi_cook_timer_if.sv - button/selector/display bundle for the multi-channel cook timer
// Purpose: groups the channel selector, debounced buttons and display/status outputs.
// Ports (signals): ch_sel, btn_start_pause, btn_add, btn_clear (button side -> timer);
//                  min, sec, running, alarm, alarm_any (timer -> display side).
// Modports: master = button/display side, slave = timer.
interface multi_cook_timer_if #(
    parameter int CHANNELS = 2
);
    import cook_timer_pkg::*;

    localparam int CW = cw_of(CHANNELS);

    logic [CW-1:0]       ch_sel;
    logic                btn_start_pause;
    logic                btn_add;
    logic                btn_clear;
    logic [7:0]          min;
    logic [7:0]          sec;
    logic [CHANNELS-1:0] running;
    logic [CHANNELS-1:0] alarm;
    logic                alarm_any;

    modport master (
        output ch_sel, btn_start_pause, btn_add, btn_clear,
        input  min, sec, running, alarm, alarm_any
    );

    modport slave (
        input  ch_sel, btn_start_pause, btn_add, btn_clear,
        output min, sec, running, alarm, alarm_any
    );

endinterface

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one countdown channel: state, min:sec and optional alarm timeout
// Purpose: IDLE/SET/RUN/ALARM state machine with saturating add and per-tick decrement.
// Ports: clk, reset_n; tick_i (1 s pulse); clear_i/add_i/start_i (already prioritised,
//        at most one high); min_o/sec_o (current time); running_o; alarm_o.
// Config: COOK_TIMER_ALARM_TIMEOUT_EN adds an ALARM_SEC-tick alarm auto-clear.
module timer_channel
    import cook_timer_pkg::*;
#(
    parameter int STEP_SEC  = 30,
    parameter int MAX_MIN   = 5
`ifdef COOK_TIMER_ALARM_TIMEOUT_EN
    ,
    parameter int ALARM_SEC = 10
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_i,
    input  logic       clear_i,
    input  logic       add_i,
    input  logic       start_i,
    output logic [7:0] min_o,
    output logic [7:0] sec_o,
    output logic       running_o,
    output logic       alarm_o
);

    localparam logic [7:0] STEP8 = 8'(STEP_SEC);
    localparam logic [7:0] MAX8  = 8'(MAX_MIN);
    localparam logic [7:0] SPM8  = 8'(SEC_PER_MIN);

    state_t     state_q, state_d;
    logic [7:0] min_q, min_d, sec_q, sec_d;
    logic [7:0] sum_sec, add_min, add_sec;
    logic       carry, sat;

`ifdef COOK_TIMER_ALARM_TIMEOUT_EN
    localparam logic [15:0] ALARM_LAST = 16'(ALARM_SEC - 1);
    logic [15:0] acnt_q, acnt_d;
`endif

    // IDLE and ALARM hold 0:00, so adding to the current time also covers "load step".
    assign sum_sec = sec_q + STEP8;
    assign carry   = (sum_sec >= SPM8);
    assign add_sec = carry ? (sum_sec - SPM8) : sum_sec;
    assign add_min = min_q + {7'd0, carry};
    assign sat     = (add_min > MAX8) || ((add_min == MAX8) && (add_sec != 8'd0));

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
`ifdef COOK_TIMER_ALARM_TIMEOUT_EN
        acnt_d  = acnt_q;
`endif
        // A button edge on this channel consumes the cycle; a coincident tick is dropped.
        if (clear_i) begin
            state_d = ST_IDLE;
            min_d   = 8'd0;
            sec_d   = 8'd0;
        end else if (add_i) begin
            min_d   = sat ? MAX8 : add_min;
            sec_d   = sat ? 8'd0 : add_sec;
            state_d = (state_q == ST_RUN) ? ST_RUN : ST_SET;
        end else if (start_i) begin
            if (state_q == ST_SET) begin
                state_d = ST_RUN;
            end else if (state_q == ST_RUN) begin
                state_d = ST_SET;
            end
        end else if (tick_i) begin
            if (state_q == ST_RUN) begin
                if (sec_q == 8'd0) begin
                    sec_d = SPM8 - 8'd1;
                    min_d = min_q - 8'd1;
                end else begin
                    sec_d = sec_q - 8'd1;
                    if ((min_q == 8'd0) && (sec_q == 8'd1)) begin
                        state_d = ST_ALARM;
`ifdef COOK_TIMER_ALARM_TIMEOUT_EN
                        acnt_d  = 16'd0;
`endif
                    end
                end
            end
`ifdef COOK_TIMER_ALARM_TIMEOUT_EN
            else if (state_q == ST_ALARM) begin
                if (acnt_q == ALARM_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    acnt_d = acnt_q + 16'd1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            min_q   <= 8'd0;
            sec_q   <= 8'd0;
`ifdef COOK_TIMER_ALARM_TIMEOUT_EN
            acnt_q  <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
`ifdef COOK_TIMER_ALARM_TIMEOUT_EN
            acnt_q  <= acnt_d;
`endif
        end
    end

    assign min_o     = min_q;
    assign sec_o     = sec_q;
    assign running_o = (state_q == ST_RUN);
    assign alarm_o   = (state_q == ST_ALARM);

endmodule

// File: rtl/multi_cook_timer.sv
// rtl/multi_cook_timer.sv - N-channel kitchen countdown timer with shared buttons and display
// Purpose: button edge detection, shared 1 s prescaler, channel demux and display mux.
// Ports: clk, reset_n (async, active low); ui (multi_cook_timer_if.slave): ch_sel,
//        btn_start_pause, btn_add, btn_clear in; min, sec, running, alarm, alarm_any out.
// Config: COOK_TIMER_ALARM_TIMEOUT_EN enables ALARM_SEC-tick alarm auto-clear per channel.
module multi_cook_timer
    import cook_timer_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int CHANNELS  = 2,
    parameter int STEP_SEC  = 30,
    parameter int MAX_MIN   = 5,
    parameter int ALARM_SEC = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    multi_cook_timer_if.slave  ui
);

    localparam int CW = cw_of(CHANNELS);
    localparam int PW = $clog2(CLK_HZ);

    logic [PW-1:0]       presc_q, presc_d;
    logic                tick;
    logic [2:0]          lvl_q, lvl_prev_q;   // {clear, add, start_pause}
    logic [2:0]          rise;
    logic                cmd_clear, cmd_add, cmd_start;
    logic [CHANNELS-1:0] sel_hit, ch_run, ch_alarm;
    logic [7:0]          ch_min [CHANNELS];
    logic [7:0]          ch_sec [CHANNELS];
    logic [7:0]          min_q, min_d, sec_q, sec_d;
    logic [CHANNELS-1:0] running_q, alarm_q;
    logic                alarm_any_q;

    assign tick    = (presc_q == PW'(CLK_HZ - 1));
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    // Only the highest-priority rising edge acts: clear > add > start_pause.
    assign rise      = lvl_q & ~lvl_prev_q;
    assign cmd_clear = rise[2];
    assign cmd_add   = rise[1] & ~rise[2];
    assign cmd_start = rise[0] & ~rise[1] & ~rise[2];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign sel_hit[i] = (ui.ch_sel == CW'(i));

        timer_channel #(
            .STEP_SEC  (STEP_SEC),
            .MAX_MIN   (MAX_MIN)
`ifdef COOK_TIMER_ALARM_TIMEOUT_EN
            ,
            .ALARM_SEC (ALARM_SEC)
`endif
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .tick_i    (tick),
            .clear_i   (cmd_clear & sel_hit[i]),
            .add_i     (cmd_add & sel_hit[i]),
            .start_i   (cmd_start & sel_hit[i]),
            .min_o     (ch_min[i]),
            .sec_o     (ch_sec[i]),
            .running_o (ch_run[i]),
            .alarm_o   (ch_alarm[i])
        );
    end

    // An out-of-range selector matches no channel and the display reads 0:00.
    always_comb begin
        min_d = 8'd0;
        sec_d = 8'd0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel_hit[i]) begin
                min_d = ch_min[i];
                sec_d = ch_sec[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q     <= '0;
            lvl_q       <= 3'd0;
            lvl_prev_q  <= 3'd0;
            min_q       <= 8'd0;
            sec_q       <= 8'd0;
            running_q   <= '0;
            alarm_q     <= '0;
            alarm_any_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            lvl_q       <= {ui.btn_clear, ui.btn_add, ui.btn_start_pause};
            lvl_prev_q  <= lvl_q;
            min_q       <= min_d;
            sec_q       <= sec_d;
            running_q   <= ch_run;
            alarm_q     <= ch_alarm;
            alarm_any_q <= |ch_alarm;
        end
    end

    assign ui.min       = min_q;
    assign ui.sec       = sec_q;
    assign ui.running   = running_q;
    assign ui.alarm     = alarm_q;
    assign ui.alarm_any = alarm_any_q;

endmodule

// File: tb/tb_multi_cook_timer.sv
// tb/tb_multi_cook_timer.sv - self-checking bench for multi_cook_timer against a seconds-based model
module tb_multi_cook_timer;
    import cook_timer_pkg::*;

    localparam int CLK_HZ = 10;
    localparam int CH     = 2;
    localparam int STEP   = 30;
    localparam int MAXM   = 5;
    localparam int ASEC   = 3;
    localparam int CAP    = MAXM * 60;
    localparam int CW     = cw_of(CH);
    localparam int M_IDLE = 0, M_SET = 1, M_RUN = 2, M_ALM = 3;
    localparam logic [2:0] B_CLR = 3'b100, B_ADD = 3'b010, B_ST = 3'b001;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    multi_cook_timer_if #(.CHANNELS(CH)) ui ();

    multi_cook_timer #(
        .CLK_HZ(CLK_HZ), .CHANNELS(CH), .STEP_SEC(STEP), .MAX_MIN(MAXM), .ALARM_SEC(ASEC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ui(ui)
    );

    // Reference model: each channel is a total number of seconds plus a mode.
    int tot [CH];
    int mode [CH];
    int acnt [CH];
    int edge_n;
    bit pend_v;
    int pend_edge, pend_ch;
    logic [2:0] pend_mask;
    logic [7:0] e_min, e_sec;
    logic [CH-1:0] e_run, e_alm;
    logic e_any;
    int n_cmp = 0, n_bad = 0;
    logic [2:0] mask_tbl [7] = '{B_ADD, B_ADD, B_ST, B_ST, B_CLR, B_CLR | B_ADD, B_ADD | B_ST};

    wire [20:0] got_vec = {ui.min, ui.sec, ui.running, ui.alarm, ui.alarm_any};
    wire [20:0] exp_vec = {e_min, e_sec, e_run, e_alm, e_any};

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CH; i++) begin
                tot[i] = 0; mode[i] = M_IDLE; acnt[i] = 0;
            end
            edge_n = 0; pend_v = 0;
            e_min = 0; e_sec = 0; e_run = 0; e_alm = 0; e_any = 0;
        end else begin
            // Outputs after this edge show the model as it stood before it.
            e_min = 0; e_sec = 0;
            if (int'(ui.ch_sel) < CH) begin
                e_min = 8'(tot[ui.ch_sel] / 60);
                e_sec = 8'(tot[ui.ch_sel] % 60);
            end
            for (int i = 0; i < CH; i++) begin
                e_run[i] = (mode[i] == M_RUN);
                e_alm[i] = (mode[i] == M_ALM);
            end
            e_any = |e_alm;
            edge_n++;
            for (int i = 0; i < CH; i++) begin
                if (pend_v && pend_edge == edge_n && pend_ch == i) begin
                    if (pend_mask[2]) begin
                        tot[i] = 0; mode[i] = M_IDLE;
                    end else if (pend_mask[1]) begin
                        tot[i] = (tot[i] + STEP > CAP) ? CAP : tot[i] + STEP;
                        if (mode[i] != M_RUN) mode[i] = M_SET;
                    end else begin
                        if (mode[i] == M_SET) mode[i] = M_RUN;
                        else if (mode[i] == M_RUN) mode[i] = M_SET;
                    end
                end else if (edge_n % CLK_HZ == 0) begin
                    if (mode[i] == M_RUN) begin
                        tot[i]--;
                        if (tot[i] == 0) begin mode[i] = M_ALM; acnt[i] = 0; end
                    end
`ifdef COOK_TIMER_ALARM_TIMEOUT_EN
                    else if (mode[i] == M_ALM) begin
                        acnt[i]++;
                        if (acnt[i] == ASEC) mode[i] = M_IDLE;
                    end
`endif
                end
            end
            if (pend_v && pend_edge == edge_n) pend_v = 0;
        end
    end

    task automatic do_reset;
        ui.ch_sel = '0; ui.btn_clear = 0; ui.btn_add = 0; ui.btn_start_pause = 0;
        reset_n = 0;
        repeat (2) @(negedge clk);
        reset_n = 1;
        @(negedge clk);
    endtask

    // Called at a negedge; the action lands on the second following edge.
    task automatic press(input int ch, input logic [2:0] mask);
        ui.ch_sel = CW'(ch);
        ui.btn_clear = mask[2]; ui.btn_add = mask[1]; ui.btn_start_pause = mask[0];
        pend_ch = ch; pend_mask = mask; pend_edge = edge_n + 2; pend_v = 1;
        repeat (4) @(negedge clk);
        ui.btn_clear = 0; ui.btn_add = 0; ui.btn_start_pause = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        do_reset();
        n_cmp++;
        if (got_vec !== 21'd0) begin
            n_bad++; $display("FAIL reset_outputs: got %h required %h", got_vec, 21'd0);
        end
    endtask

    task automatic test_add_saturate;
        do_reset();
        repeat (3) press(0, B_ADD);
        n_cmp++;
        if ({ui.min, ui.sec} !== {8'd1, 8'd30}) begin
            n_bad++; $display("FAIL add_1_30: got %0d:%0d required 1:30", ui.min, ui.sec);
        end
        repeat (12) press(0, B_ADD);
        n_cmp++;
        if ({ui.min, ui.sec} !== {8'd5, 8'd0}) begin
            n_bad++; $display("FAIL add_sat: got %0d:%0d required 5:00", ui.min, ui.sec);
        end
        press(0, B_ADD);
        n_cmp++;
        if ({ui.min, ui.sec, ui.running} !== {8'd5, 8'd0, 2'b00}) begin
            n_bad++; $display("FAIL add_at_max: got %0d:%0d run %b required 5:00 run 00", ui.min, ui.sec, ui.running);
        end
        n_cmp++;
        if (got_vec !== exp_vec) begin
            n_bad++; $display("FAIL add_model: got %h required %h", got_vec, exp_vec);
        end
    endtask

    task automatic test_countdown;
        press(0, B_CLR);
        press(0, B_ADD);
        press(0, B_ST);
        n_cmp++;
        if (ui.running[0] !== 1'b1) begin
            n_bad++; $display("FAIL start_running: got %b required 1", ui.running[0]);
        end
        for (int c = 0; c < 400 && !ui.alarm[0]; c++) begin
            @(negedge clk);
            n_cmp++;
            if (got_vec !== exp_vec) begin
                n_bad++; $display("FAIL countdown_cycle %0d: got %h required %h", c, got_vec, exp_vec);
            end
        end
        n_cmp++;
        if ({ui.min, ui.sec, ui.alarm[0], ui.alarm_any, ui.running[0]} !== {8'd0, 8'd0, 3'b110}) begin
            n_bad++;
            $display("FAIL countdown_end: got %0d:%0d alarm %b any %b run %b required 0:00 1 1 0",
                     ui.min, ui.sec, ui.alarm[0], ui.alarm_any, ui.running[0]);
        end
    endtask

    task automatic test_two_channels;
        press(1, B_CLR);
        repeat (2) press(1, B_ADD);
        press(0, B_CLR);
        repeat (4) press(0, B_ADD);
        press(0, B_ST);
        ui.ch_sel = CW'(1);
        @(negedge clk);
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({ui.min, ui.sec} !== {8'd1, 8'd0} || got_vec !== exp_vec) begin
                n_bad++; $display("FAIL ch1_hold cycle %0d: got %h required %h (1:00)", c, got_vec, exp_vec);
            end
        end
        ui.ch_sel = CW'(0);
        @(negedge clk);
        n_cmp++;
        if (!({ui.min, ui.sec} < {8'd2, 8'd0}) || ui.running !== 2'b01 || got_vec !== exp_vec) begin
            n_bad++; $display("FAIL ch0_moving: got %h required %h", got_vec, exp_vec);
        end
    endtask

    task automatic test_priority;
        press(0, B_CLR);
        repeat (4) press(0, B_ADD);
        press(0, B_CLR | B_ADD);
        n_cmp++;
        if ({ui.min, ui.sec, ui.running[0], ui.alarm[0]} !== {8'd0, 8'd0, 2'b00} || got_vec !== exp_vec) begin
            n_bad++; $display("FAIL clear_over_add: got %h required %h (0:00 idle)", got_vec, exp_vec);
        end
        repeat (2) press(0, B_ADD);
        press(0, B_ST);
        for (int c = 0; c < 300 && tot[0] != 59; c++) @(negedge clk);
        for (int c = 0; c < 12 && (edge_n % CLK_HZ) != CLK_HZ - 2; c++) @(negedge clk);
        n_cmp++;
        if ({ui.min, ui.sec} !== {8'd0, 8'd59}) begin
            n_bad++; $display("FAIL reach_0_59: got %0d:%0d required 0:59", ui.min, ui.sec);
        end
        press(0, B_ADD);
        n_cmp++;
        if ({ui.min, ui.sec, ui.running[0]} !== {8'd1, 8'd29, 1'b1}) begin
            n_bad++; $display("FAIL add_on_tick: got %0d:%0d run %b required 1:29 run 1", ui.min, ui.sec, ui.running[0]);
        end
    endtask

    task automatic test_reset_midrun;
        press(0, B_CLR);
        repeat (7) press(0, B_ADD);
        press(0, B_ST);
        for (int c = 0; c < 400 && tot[0] != 197; c++) @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({ui.min, ui.sec} !== {8'd3, 8'd17}) begin
            n_bad++; $display("FAIL reach_3_17: got %0d:%0d required 3:17", ui.min, ui.sec);
        end
        #2 reset_n = 0;
        #1;
        n_cmp++;
        if (got_vec !== 21'd0) begin
            n_bad++; $display("FAIL async_reset: got %h required %h", got_vec, 21'd0);
        end
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        press(0, B_ST);
        n_cmp++;
        if (got_vec !== 21'd0 || got_vec !== exp_vec) begin
            n_bad++; $display("FAIL start_in_idle: got %h required %h", got_vec, 21'd0);
        end
    endtask

    task automatic test_alarm_hold;
        do_reset();
        press(1, B_ADD);
        press(1, B_ST);
        for (int c = 0; c < 400 && !ui.alarm[1]; c++) @(negedge clk);
        n_cmp++;
        if (ui.alarm[1] !== 1'b1) begin
            n_bad++; $display("FAIL alarm1_rise: got %b required 1", ui.alarm[1]);
        end
`ifdef COOK_TIMER_ALARM_TIMEOUT_EN
        for (int c = 0; c < ASEC * CLK_HZ + 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (got_vec !== exp_vec) begin
                n_bad++; $display("FAIL alarm_timeout_cycle %0d: got %h required %h", c, got_vec, exp_vec);
            end
        end
        n_cmp++;
        if ({ui.alarm[1], ui.alarm_any} !== 2'b00) begin
            n_bad++; $display("FAIL alarm_timeout: got %b%b required 00", ui.alarm[1], ui.alarm_any);
        end
`else
        for (int c = 0; c < 20 * CLK_HZ; c++) begin
            @(negedge clk);
            n_cmp++;
            if (got_vec !== exp_vec) begin
                n_bad++; $display("FAIL alarm_hold_cycle %0d: got %h required %h", c, got_vec, exp_vec);
            end
        end
        n_cmp++;
        if ({ui.alarm[1], ui.alarm_any} !== 2'b11) begin
            n_bad++; $display("FAIL alarm_hold: got %b%b required 11", ui.alarm[1], ui.alarm_any);
        end
        press(1, B_CLR);
        n_cmp++;
        if ({ui.alarm[1], ui.alarm_any} !== 2'b00) begin
            n_bad++; $display("FAIL alarm_clear: got %b%b required 00", ui.alarm[1], ui.alarm_any);
        end
`endif
    endtask

    task automatic test_random;
        do_reset();
        for (int it = 0; it < 60; it++) begin
            press($urandom_range(0, CH - 1), mask_tbl[$urandom_range(0, 6)]);
            ui.ch_sel = CW'($urandom_range(0, CH - 1));
            for (int c = 0, n = $urandom_range(1, 40); c < n; c++) begin
                @(negedge clk);
                n_cmp++;
                if (got_vec !== exp_vec) begin
                    n_bad++; $display("FAIL random it %0d cycle %0d: got %h required %h", it, c, got_vec, exp_vec);
                end
            end
        end
    endtask

    initial begin
        ui.ch_sel = '0; ui.btn_clear = 0; ui.btn_add = 0; ui.btn_start_pause = 0;
        @(negedge clk);
        test_reset();
        test_add_saturate();
        test_countdown();
        test_two_channels();
        test_priority();
        test_reset_midrun();
        test_alarm_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_cook_timer.md
# multi_cook_timer

Parametrised N-channel kitchen countdown timer, the successor to the single-channel cook timer. One shared button set and a channel selector program any channel. Each channel counts down independently from a shared 1 s prescaler and raises its own alarm at 0:00. It sits between the debounced button block and the FND display driver and presents the selected channel's min/sec to the display.

## Interface
- CLK_HZ, 100_000_000: clock cycles per 1 s tick; must be ≥2.
- CHANNELS, 2: number of independent timers, 1..8.
- STEP_SEC, 30: seconds added per add press, 1..59.
- MAX_MIN, 5: saturation ceiling is MAX_MIN:00; MAX_MIN is 1..99.
- ALARM_SEC, 10: alarm auto-clear time in ticks; used only with the macro.
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ch_sel  in  CW  channel addressed by buttons and display; CW = max(1, clog2(CHANNELS)).
- btn_start_pause  in  1  debounced level; its rising edge toggles run/pause.
- btn_add  in  1  debounced level; its rising edge adds STEP_SEC.
- btn_clear  in  1  debounced level; its rising edge zeroes the channel and silences it.
- min  out  8  selected channel minutes, binary, registered.
- sec  out  8  selected channel seconds, binary 0..59, registered.
- running  out  CHANNELS  per-channel RUN flag.
- alarm  out  CHANNELS  per-channel alarm flag.
- alarm_any  out  1  OR of alarm, registered.

## Operation
- Reset (reset_n low, any time): every channel goes to IDLE at 0:00; the prescaler is zeroed; min, sec, running, alarm and alarm_any are all 0.
- Button edges are detected internally: edge = level AND NOT the previous registered level. Edges apply to channel ch_sel only.
- Priority within one cycle is clear > add > start_pause. Only the highest-priority edge acts.
- Per-channel states are IDLE, SET, RUN and ALARM.
  - IDLE: time is 0:00. Add moves to SET. Start is ignored.
  - SET: time is non-zero and paused. Start moves to RUN. Add adds time. Clear moves to IDLE.
  - RUN: a tick decrements the time. When 0:01 decrements to 0:00, the channel moves to ALARM. Start moves to SET (pause). Add adds time and the channel stays in RUN. Clear moves to IDLE.
  - ALARM: time is 0:00 and alarm=1. Clear moves to IDLE. Add moves to SET with the step loaded. Start is ignored.
- Add arithmetic: s = sec + STEP_SEC. If s ≥ 60, then sec = s − 60 and min + 1; otherwise sec = s. If the result exceeds MAX_MIN:00, it saturates to exactly MAX_MIN:00. Adding at MAX_MIN:00 leaves the time unchanged.
- Decrement: at sec = 0, sec = 59 and min − 1; otherwise sec − 1.
- The prescaler is free-running and shared. The tick is a 1-cycle pulse every CLK_HZ cycles. The prescaler is never reset by buttons, so the first decrement after start occurs within 1..CLK_HZ cycles.
- If a tick and a button edge target the same channel in the same cycle, the button wins and that channel's tick is dropped. Other running channels still decrement.
- If ch_sel ≥ CHANNELS, button edges are ignored and min and sec read 0.

## Timing
- Button rise to state change: the state register updates 2 edges after the first high sample.
- Button rise to min/sec, running and alarm change: 3 edges.
- Tick to min/sec change: 2 edges. running and alarm follow the state with 1 register.
- A ch_sel change appears on min/sec 1 edge later.
- A level held high produces one action only; a new rise is required for the next action.

## Configuration
- COOK_TIMER_ALARM_TIMEOUT_EN defined: ALARM counts ALARM_SEC ticks, then moves to IDLE and alarm drops automatically. Any button action on that channel before timeout behaves as in the state list above.
- COOK_TIMER_ALARM_TIMEOUT_EN undefined: ALARM holds until clear, add or reset. ALARM_SEC and its counter are not synthesised.

## Structure
- Package cook_timer_pkg holds the state enum (IDLE/SET/RUN/ALARM), the SEC_PER_MIN=60 constant, and the helper function computing CW from CHANNELS.
- Sub-module timer_channel holds one channel's state, min, sec and alarm-timeout counter. It is instantiated CHANNELS times via generate. The top level holds the edge detectors, prescaler, select demux and output mux.

## Test plan
All scenarios run with CLK_HZ=10, CHANNELS=2, STEP_SEC=30, MAX_MIN=5 and ALARM_SEC=3.
- Ch0: 3 add presses → min/sec = 1:30. 12 further presses → 5:00, and a 13th press leaves it at 5:00.
- Ch0 set to 0:30, start → running[0]=1. After 30 ticks → 0:00, alarm[0]=1, alarm_any=1, running[0]=0.
- Ch0 running and ch1 paused at 1:00; select ch1 → display 1:00, which is unchanged across ticks, while ch0 keeps decrementing.
- Clear and add rising in the same cycle on ch0 at 2:00 → 0:00, IDLE, no add. Add on a tick cycle → 0:59 becomes 1:29, and that tick is dropped for ch0.
- reset_n pulsed low mid-run at 3:17 → all outputs 0 asynchronously. After release, a start press is ignored (IDLE).
- With the macro defined: alarm[1] falls after 3 ticks. Without it: alarm[1] is still high after 20 ticks and clears on the clear edge.
